// File: rtl/vertex_transform_pipe.sv
// vertex_transform_pipe
//   Applies a loadable 4x4 matrix to a homogeneous vertex (x,y,z,w), then does a
//   perspective divide and a viewport scale/offset to give screen coordinates.
//   It uses four shared multipliers (one per matrix row) and two radix-2
//   restoring dividers that run in parallel.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   vertex handshake; in_x..in_w are signed W-bit values
//   mat_we/addr/wdata   shadow matrix write, addr = (row-1)*4 + (col-1)
//   out_valid/out_ready result handshake; out_sx/out_sy are signed W-bit
//   out_div0            cw was zero, so the outputs are the viewport offsets
module vertex_transform_pipe #(
    parameter int W        = 10,
    parameter int SCALE_X  = 320,
    parameter int SCALE_Y  = 240,
    parameter int OFFSET_X = 0,
    parameter int OFFSET_Y = 0,
    parameter int CAMZ     = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_x,
    input  logic [W-1:0] in_y,
    input  logic [W-1:0] in_z,
    input  logic [W-1:0] in_w,
    input  logic         mat_we,
    input  logic [3:0]   mat_addr,
    input  logic [W-1:0] mat_wdata,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sx,
    output logic [W-1:0] out_sy,
    output logic         out_div0
);
    localparam int PW   = 2 * W;
    localparam int AW   = 2 * W + 2;
    localparam int CNTW = $clog2(PW);

    localparam logic signed [W-1:0] SX = W'(SCALE_X);
    localparam logic signed [W-1:0] SY = W'(SCALE_Y);
    localparam logic [W-1:0]        OX = W'(OFFSET_X);
    localparam logic [W-1:0]        OY = W'(OFFSET_Y);

    // Matrix is kept flat: entry i lives at [i*W +: W], i = row*4 + col.
    function automatic logic [16*W-1:0] mat_default();
        logic [16*W-1:0] m;
        m            = '0;
        m[0*W  +: W] = W'(1);
        m[5*W  +: W] = W'(1);
        m[10*W +: W] = W'(-1);
        m[14*W +: W] = W'(-1);
        m[11*W +: W] = W'(CAMZ);
        m[15*W +: W] = W'(CAMZ);
        return m;
    endfunction

    localparam logic [16*W-1:0] MAT_DEF = mat_default();

    typedef enum logic [2:0] {IDLE, MAC, SCALE, DIV, OUT} state_t;
    state_t state, state_nx;

    logic [16*W-1:0]       shadow, active;
    logic [4*W-1:0]        vtx;
    logic [CNTW-1:0]       cnt;
    logic [3:0][AW-1:0]    acc, acc_nx;
    logic [3:0][PW-1:0]    prod;
    logic signed [W-1:0]   comp;

    // Divider lanes: 0 = x, 1 = y. dq starts as the dividend magnitude and
    // shifts left each step, collecting quotient bits at the bottom.
    logic [1:0][PW-1:0]    dq, dq_nx;
    logic [1:0][W-1:0]     rem, rem_nx;
    logic [1:0][W-1:0]     qw;
    logic [1:0]            neg;
    logic [W-1:0]          dvs;
    logic                  div0;

    logic signed [W-1:0]   cx, cy, cw;
    logic signed [PW-1:0]  nx, ny;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);

    // MAC step k multiplies component k by column k of every row.
    assign comp = vtx[cnt[1:0]*W +: W];

    for (genvar r = 0; r < 4; r++) begin : g_row
        logic signed [W-1:0] coef;
        assign coef      = active[(r*4 + int'(cnt[1:0]))*W +: W];
        assign prod[r]   = PW'(comp) * PW'(coef);
        assign acc_nx[r] = acc[r] + AW'($signed(prod[r]));
    end

    // Clip-space values wrap to W bits before scaling.
    assign cx = acc[0][W-1:0];
    assign cy = acc[1][W-1:0];
    assign cw = acc[3][W-1:0];
    assign nx = PW'(SX) * PW'(cx);
    assign ny = PW'(SY) * PW'(cy);

    for (genvar l = 0; l < 2; l++) begin : g_div
        logic [W:0] trial;
        logic       ge;
        assign trial     = {rem[l], dq[l][PW-1]};
        assign ge        = trial >= {1'b0, dvs};
        assign rem_nx[l] = ge ? W'(trial - {1'b0, dvs}) : trial[W-1:0];
        assign dq_nx[l]  = {dq[l][PW-2:0], ge};
        // Sign applied to the magnitude quotient gives truncation toward zero.
        assign qw[l]     = neg[l] ? W'(-dq_nx[l]) : dq_nx[l][W-1:0];
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = MAC;
            MAC:     if (cnt[1:0] == 2'd3) state_nx = SCALE;
            SCALE:   state_nx = DIV;
            DIV:     if (cnt == CNTW'(PW - 1)) state_nx = OUT;
            OUT:     if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shadow   <= MAT_DEF;
            active   <= MAT_DEF;
            vtx      <= '0;
            cnt      <= '0;
            acc      <= '0;
            dq       <= '0;
            rem      <= '0;
            neg      <= '0;
            dvs      <= '0;
            div0     <= 1'b0;
            out_sx   <= '0;
            out_sy   <= '0;
            out_div0 <= 1'b0;
        end else begin
            state <= state_nx;
            // The active copy below samples shadow before this write lands,
            // so a same-edge write only affects the next vertex.
            if (mat_we) shadow[mat_addr*W +: W] <= mat_wdata;
            case (state)
                IDLE: if (in_valid) begin
                    vtx    <= {in_w, in_z, in_y, in_x};
                    active <= shadow;
                    acc    <= '0;
                    cnt    <= '0;
                end
                MAC: begin
                    acc <= acc_nx;
                    cnt <= cnt + 1'b1;
                end
                SCALE: begin
                    dq[0]  <= nx[PW-1] ? PW'(-nx) : PW'(nx);
                    dq[1]  <= ny[PW-1] ? PW'(-ny) : PW'(ny);
                    neg[0] <= nx[PW-1] ^ cw[W-1];
                    neg[1] <= ny[PW-1] ^ cw[W-1];
                    dvs    <= cw[W-1] ? W'(-cw) : W'(cw);
                    div0   <= (cw == '0);
                    rem    <= '0;
                    cnt    <= '0;
                end
                DIV: begin
                    dq  <= dq_nx;
                    rem <= rem_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNTW'(PW - 1)) begin
                        // Divider still runs on cw==0 to keep latency fixed;
                        // its result is simply ignored.
                        out_sx   <= div0 ? OX : qw[0] + OX;
                        out_sy   <= div0 ? OY : qw[1] + OY;
                        out_div0 <= div0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_vertex_transform_pipe.sv
module tb_vertex_transform_pipe;
    localparam int W = 10, SX = 320, SY = 240, OX = 0, OY = 0, CAMZ = 4;
    localparam int LAT = 2 * W + 6;

    logic         clk = 0, rst = 0, in_valid = 0, mat_we = 0, out_ready = 0;
    logic [W-1:0] in_x = '0, in_y = '0, in_z = '0, in_w = '0, mat_wdata = '0;
    logic [3:0]   mat_addr = '0;
    logic         in_ready, out_valid, out_div0;
    logic [W-1:0] out_sx, out_sy;

    vertex_transform_pipe #(.W(W), .SCALE_X(SX), .SCALE_Y(SY), .OFFSET_X(OX),
                            .OFFSET_Y(OY), .CAMZ(CAMZ)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_w(in_w),
        .mat_we(mat_we), .mat_addr(mat_addr), .mat_wdata(mat_wdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sx(out_sx), .out_sy(out_sy), .out_div0(out_div0));

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int m[16];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic int wrapw(input int a);
        int r;
        r = a & ((1 << W) - 1);
        if (r >= (1 << (W - 1))) r -= (1 << W);
        return r;
    endfunction

    function automatic void model_reset();
        foreach (m[i]) m[i] = 0;
        m[0] = 1; m[5] = 1; m[10] = -1; m[14] = -1; m[11] = CAMZ; m[15] = CAMZ;
    endfunction

    // Matrix-vector product, wrap, scale, integer divide (toward zero), offset.
    function automatic void model(input int x, y, z, w, output int sx, sy, d0);
        int v[4];
        int c[4];
        v = '{x, y, z, w};
        for (int r = 0; r < 4; r++) begin
            c[r] = 0;
            for (int k = 0; k < 4; k++) c[r] += m[r*4 + k] * v[k];
            c[r] = wrapw(c[r]);
        end
        if (c[3] == 0) begin
            sx = wrapw(OX); sy = wrapw(OY); d0 = 1;
        end else begin
            sx = wrapw((SX * c[0]) / c[3] + OX);
            sy = wrapw((SY * c[1]) / c[3] + OY);
            d0 = 0;
        end
    endfunction

    // All tasks start and end just after a falling edge.
    task automatic do_reset();
        rst = 1;
        @(posedge clk); @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    task automatic wr(input int addr, input int data);
        mat_we = 1; mat_addr = addr[3:0]; mat_wdata = data[W-1:0];
        @(posedge clk); @(negedge clk);
        mat_we = 0;
        m[addr] = data;
    endtask

    // Present a vertex (optionally with a same-edge matrix write) and return
    // just after the accepting edge. Model shadow is updated after the accept.
    task automatic send(input int x, y, z, w, input bit we, input int addr, data);
        int n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); @(negedge clk); n++; end
        if (n == 100) check("in_ready_timeout", 0, 1);
        in_valid = 1;
        in_x = x[W-1:0]; in_y = y[W-1:0]; in_z = z[W-1:0]; in_w = w[W-1:0];
        mat_we = we; mat_addr = addr[3:0]; mat_wdata = data[W-1:0];
        @(posedge clk); @(negedge clk);
        in_valid = 0; mat_we = 0;
    endtask

    // Latency counts the accepting edge as edge 1.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin @(posedge clk); lat++; @(negedge clk); end
    endtask

    task automatic get(output int sx, sy, d0, lat);
        wait_valid(lat);
        sx = int'($signed(out_sx)); sy = int'($signed(out_sy)); d0 = int'(out_div0);
        out_ready = 1;
        @(posedge clk); @(negedge clk);
        out_ready = 0;
    endtask

    typedef struct { int x, y, z, w, sx, sy, d0; } vec_t;
    vec_t tbl[6];

    initial begin
        int sx, sy, d0, lat, esx, esy, ed0;
        tbl[0] = '{1, 2, 0, 1, 80, 120, 0};
        tbl[1] = '{1, 0, 1, 1, 106, 0, 0};
        tbl[2] = '{-1, 0, 1, 1, -106, 0, 0};
        tbl[3] = '{0, 0, 4, 1, 0, 0, 1};
        tbl[4] = '{3, -2, 2, 1, 480, -240, 0};
        tbl[5] = '{0, 0, 0, 1, 0, 0, 0};

        @(negedge clk);
        do_reset();
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_sx", int'(out_sx), 0);
        check("rst_sy", int'(out_sy), 0);
        check("rst_div0", int'(out_div0), 0);

        foreach (tbl[i]) begin
            send(tbl[i].x, tbl[i].y, tbl[i].z, tbl[i].w, 0, 0, 0);
            get(sx, sy, d0, lat);
            check($sformatf("tbl%0d_sx", i), sx, tbl[i].sx);
            check($sformatf("tbl%0d_sy", i), sy, tbl[i].sy);
            check($sformatf("tbl%0d_div0", i), d0, tbl[i].d0);
            check($sformatf("tbl%0d_lat", i), lat, LAT);
        end

        // a14 = 3 written ahead of the vertex
        wr(3, 3);
        send(1, 2, 0, 1, 0, 0, 0);
        get(sx, sy, d0, lat);
        check("a14_sx", sx, 320);
        check("a14_sy", sy, 120);

        // same-edge write: first vertex sees old shadow, second sees new
        do_reset();
        send(1, 2, 0, 1, 1, 3, 3);
        get(sx, sy, d0, lat);
        check("same_edge_first_sx", sx, 80);
        send(1, 2, 0, 1, 0, 0, 0);
        get(sx, sy, d0, lat);
        check("same_edge_second_sx", sx, 320);

        // backpressure with a pending second vertex
        do_reset();
        send(1, 2, 0, 1, 0, 0, 0);
        wait_valid(lat);
        check("bp_lat", lat, LAT);
        in_valid = 1; in_x = 10'd1; in_y = 10'd0; in_z = 10'd1; in_w = 10'd1;
        for (int i = 0; i < 10; i++) begin
            check("bp_sx_stable", int'($signed(out_sx)), 80);
            check("bp_sy_stable", int'($signed(out_sy)), 120);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_in_ready", int'(in_ready), 0);
            @(posedge clk); @(negedge clk);
        end
        out_ready = 1;
        @(posedge clk); @(negedge clk);
        out_ready = 0;
        check("bp_consumed_out_valid", int'(out_valid), 0);
        check("bp_idle_in_ready", int'(in_ready), 1);
        @(posedge clk); @(negedge clk);
        check("bp_second_accepted", int'(in_ready), 0);
        in_valid = 0;
        get(sx, sy, d0, lat);
        check("bp_second_sx", sx, 106);
        check("bp_second_lat", lat, LAT);

        // throughput with out_ready held high and in_valid held high
        begin
            int e = 0, a0 = -1, a1 = -1;
            in_valid = 1; out_ready = 1;
            in_x = 10'd1; in_y = 10'd2; in_z = 10'd0; in_w = 10'd1;
            while (a1 < 0 && e < 200) begin
                if (in_ready) begin
                    if (a0 < 0) a0 = e; else a1 = e;
                end
                @(posedge clk); e++; @(negedge clk);
            end
            in_valid = 0;
            check("throughput", a1 - a0, 2 * W + 7);
            e = 0;
            while (!in_ready && e < 100) begin @(posedge clk); @(negedge clk); e++; end
            out_ready = 0;
        end

        // reset in the middle of DIV discards vertex and matrix write
        wr(3, 3);
        send(1, 2, 0, 1, 0, 0, 0);
        repeat (9) begin @(posedge clk); @(negedge clk); end
        do_reset();
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_in_ready", int'(in_ready), 1);
        check("mid_rst_sx", int'(out_sx), 0);
        send(1, 2, 0, 1, 0, 0, 0);
        get(sx, sy, d0, lat);
        check("post_rst_sx", sx, 80);
        check("post_rst_sy", sy, 120);

        // randomized vertices and matrix writes against the model
        for (int i = 0; i < 40; i++) begin
            int x, y, z, w, a, d;
            bit same;
            if ($urandom_range(0, 3) == 0) x = wrapw(int'($urandom));
            else x = int'($urandom_range(0, 30)) - 15;
            y = int'($urandom_range(0, 30)) - 15;
            z = int'($urandom_range(0, 16)) - 8;
            w = int'($urandom_range(0, 8)) - 4;
            a = int'($urandom_range(0, 15));
            d = int'($urandom_range(0, 10)) - 5;
            same = ($urandom_range(0, 3) == 0);
            if (!same && $urandom_range(0, 2) == 0) wr(a, d);
            model(x, y, z, w, esx, esy, ed0);
            send(x, y, z, w, same, a, d);
            if (same) m[a] = d;
            get(sx, sy, d0, lat);
            check($sformatf("rnd%0d_sx", i), sx, esx);
            check($sformatf("rnd%0d_sy", i), sy, esy);
            check($sformatf("rnd%0d_div0", i), d0, ed0);
            check($sformatf("rnd%0d_lat", i), lat, LAT);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
